// File: rtl/if_id_skid_reg_if.sv
// Signal bundle between the fetch stage, the IF/ID skid register and the decode stage.
// The stage uses the slave modport; the environment that drives it uses master.
interface if_id_skid_reg_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
);
    logic               up_valid;
    logic               up_ready;
    logic [INSTR_W-1:0] up_instrn;
    logic [ADDR_W-1:0]  up_pc;
    logic [ADDR_W-1:0]  up_pcp4;
    logic               flush;
    logic               clr_cnt;
    logic               down_valid;
    logic               down_ready;
    logic [INSTR_W-1:0] down_instrn;
    logic [ADDR_W-1:0]  down_pc;
    logic [ADDR_W-1:0]  down_pcp4;
    logic [CNT_W-1:0]   stall_cnt;

    modport slave (
        input  up_valid, up_instrn, up_pc, up_pcp4, flush, clr_cnt, down_ready,
        output up_ready, down_valid, down_instrn, down_pc, down_pcp4, stall_cnt
    );

    modport master (
        output up_valid, up_instrn, up_pc, up_pcp4, flush, clr_cnt, down_ready,
        input  up_ready, down_valid, down_instrn, down_pc, down_pcp4, stall_cnt
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, so up_ready can be a flop
// while still sustaining one instruction per cycle, plus a saturating stall counter.
module if_id_skid_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_id_skid_reg_if.slave       bus,
    output logic [1:0]            dbg_state
);
    // Handshake: a word moves on a rising edge when valid and ready are both high
    // on that side; once valid is raised the sender holds its data until it moves,
    // and ready never depends combinationally on the opposite side.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               up_ready_q, up_ready_d;
    logic [INSTR_W-1:0] main_instrn_q, main_instrn_d;
    logic [ADDR_W-1:0]  main_pc_q, main_pc_d;
    logic [ADDR_W-1:0]  main_pcp4_q, main_pcp4_d;
    logic [INSTR_W-1:0] skid_instrn_q, skid_instrn_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic [ADDR_W-1:0]  skid_pcp4_q, skid_pcp4_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic down_valid;
    logic accept;
    logic drain;

    assign down_valid = (state_q != ST_EMPTY);
    assign accept     = bus.up_valid & up_ready_q;
    assign drain      = down_valid & bus.down_ready;

    always_comb begin
        state_d       = state_q;
        main_instrn_d = main_instrn_q;
        main_pc_d     = main_pc_q;
        main_pcp4_d   = main_pcp4_q;
        skid_instrn_d = skid_instrn_q;
        skid_pc_d     = skid_pc_q;
        skid_pcp4_d   = skid_pcp4_q;

        if (bus.flush) begin
            state_d       = ST_EMPTY;
            main_instrn_d = NOP_INSTR;
            main_pc_d     = '0;
            main_pcp4_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d       = ST_ONE;
                        main_instrn_d = bus.up_instrn;
                        main_pc_d     = bus.up_pc;
                        main_pcp4_d   = bus.up_pcp4;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_instrn_d = bus.up_instrn;
                        main_pc_d     = bus.up_pc;
                        main_pcp4_d   = bus.up_pcp4;
                    end else if (accept) begin
                        // Main is stalled; park the new word behind it.
                        state_d       = ST_FULL;
                        skid_instrn_d = bus.up_instrn;
                        skid_pc_d     = bus.up_pc;
                        skid_pcp4_d   = bus.up_pcp4;
                    end else if (drain) begin
                        state_d       = ST_EMPTY;
                        main_instrn_d = NOP_INSTR;
                        main_pc_d     = '0;
                        main_pcp4_d   = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d       = ST_ONE;
                        main_instrn_d = skid_instrn_q;
                        main_pc_d     = skid_pc_q;
                        main_pcp4_d   = skid_pcp4_q;
                    end
                end
                default: begin
                    state_d       = ST_EMPTY;
                    main_instrn_d = NOP_INSTR;
                    main_pc_d     = '0;
                    main_pcp4_d   = '0;
                end
            endcase
        end

        // Registered ready: the skid slot is free in every state except FULL.
        up_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.clr_cnt) begin
            stall_cnt_d = '0;
        end else if (down_valid && !bus.down_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            up_ready_q    <= 1'b1;
            main_instrn_q <= NOP_INSTR;
            main_pc_q     <= '0;
            main_pcp4_q   <= '0;
            skid_instrn_q <= '0;
            skid_pc_q     <= '0;
            skid_pcp4_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            up_ready_q    <= up_ready_d;
            main_instrn_q <= main_instrn_d;
            main_pc_q     <= main_pc_d;
            main_pcp4_q   <= main_pcp4_d;
            skid_instrn_q <= skid_instrn_d;
            skid_pc_q     <= skid_pc_d;
            skid_pcp4_q   <= skid_pcp4_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.up_ready    = up_ready_q;
    assign bus.down_valid  = down_valid;
    assign bus.down_instrn = main_instrn_q;
    assign bus.down_pc     = main_pc_q;
    assign bus.down_pcp4   = main_pcp4_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign dbg_state       = state_q;
endmodule
